dpc_badpoint_sched: RTL

Double-buffered bad-pixel coordinate scheduler for the dead-pixel-correction kernel. It holds a raster-sorted list of bad-pixel coordinates in two banks. It walks the active list in step with the input pixel stream and raises a same-cycle `bad_hit` flag that is tagged onto the pixel entering the line buffers. The host rewrites the shadow bank while a frame is running, and the swap takes effect only at a frame boundary.

---
 rtl/dpc_pkg.sv | 18 +
 rtl/dpc_bp_ram.sv | 26 ++
 rtl/dpc_badpoint_sched.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/dpc_pkg.sv
// rtl/dpc_pkg.sv - shared field offsets, defaults and state encoding for the bad-pixel scheduler
package dpc_pkg;

   localparam int X_LSB              = 0;
   localparam int Y_LSB              = 16;
   localparam int DEFAULT_MAX_POINTS = 128;

   // Preload spends cycles 0..PRELOAD_LAST: two read issues plus one read-latency cycle.
   localparam logic [1:0] PRELOAD_LAST = 2'd2;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PRELOAD = 2'd1,
      ARMED   = 2'd2,
      DONE    = 2'd3
   } dpc_state_t;

endpackage

// File: rtl/dpc_bp_ram.sv
// rtl/dpc_bp_ram.sv - simple dual-port coordinate RAM holding both banks, one-cycle registered read
module dpc_bp_ram #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 20
) (
   input  logic              clk,
   input  logic              wen,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              ren,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [2**ADDR_W];

   always_ff @(posedge clk) begin
      if (wen) begin
         mem[waddr] <= wdata;
      end
      if (ren) begin
         rdata <= mem[raddr];
      end
   end

endmodule

// File: rtl/dpc_badpoint_sched.sv
// rtl/dpc_badpoint_sched.sv - double-buffered bad-pixel list walker raising a same-cycle hit flag
module dpc_badpoint_sched
   import dpc_pkg::*;
#(
   parameter int CNT_WIDTH      = 10,
   parameter int MAX_POINTS     = DEFAULT_MAX_POINTS,
   parameter int PTR_W          = 7,
   parameter int AXI_DATA_WIDTH = 32
) (
   input  logic                      axis_aclk,
   input  logic                      reset,
   input  logic                      cfg_wen,
   input  logic [PTR_W-1:0]          cfg_waddr,
   input  logic [AXI_DATA_WIDTH-1:0] cfg_wdata,
   input  logic                      cfg_commit,
   input  logic [PTR_W:0]            cfg_num,
   output logic                      cfg_ready,
   input  logic                      pix_valid,
   input  logic [CNT_WIDTH-1:0]      in_hcnt,
   input  logic [CNT_WIDTH-1:0]      in_vcnt,
   input  logic                      frame_end,
   output logic                      bad_hit,
   output logic                      active_bank,
   output logic [PTR_W:0]            hit_count,
   output logic                      underrun,
   output logic                      order_err
);

   localparam int             ENTRY_W = 2 * CNT_WIDTH;
   localparam logic [PTR_W:0] MAX_NUM = (PTR_W+1)'(MAX_POINTS);

   dpc_state_t state, state_d;

   logic [1:0]           pl_cnt;
   logic                 pend;
   logic [PTR_W:0]       pend_num;
   logic [PTR_W:0]       num;
   logic [PTR_W:0]       num_d;
   logic                 bank_d;
   logic                 swap;
   logic                 wr_acc;
   logic                 commit_acc;
   logic [PTR_W:0]       hit_cnt;
   logic [PTR_W:0]       cur_idx;
   logic [PTR_W-1:0]     ptr;
   logic [PTR_W-1:0]     rd_idx;
   logic                 rd_en;
   logic                 rd_pend;
   logic                 cur_valid;
   logic                 past;
   logic                 advance;
   logic                 last;
   logic [ENTRY_W-1:0]   wr_entry;
   logic [ENTRY_W-1:0]   rdata;
   logic [ENTRY_W-1:0]   cur;
   logic [ENTRY_W-1:0]   nxt;
   logic [ENTRY_W-1:0]   nxt_eff;
   logic [CNT_WIDTH-1:0] cur_x;
   logic [CNT_WIDTH-1:0] cur_y;
   logic                 unused_cfg_bits;

   assign unused_cfg_bits = ^{cfg_wdata[AXI_DATA_WIDTH-1:Y_LSB+CNT_WIDTH],
                              cfg_wdata[Y_LSB-1:X_LSB+CNT_WIDTH]};

   // Entries are stored packed as {y, x}.
   assign wr_entry = {cfg_wdata[Y_LSB +: CNT_WIDTH], cfg_wdata[X_LSB +: CNT_WIDTH]};
   assign cur_x    = cur[CNT_WIDTH-1:0];
   assign cur_y    = cur[ENTRY_W-1:CNT_WIDTH];

   assign cfg_ready  = ~pend;
   assign wr_acc     = cfg_wen & ~pend;
   assign commit_acc = cfg_commit & ~pend;
   assign swap       = frame_end & pend;
   assign bank_d     = swap ? ~active_bank : active_bank;
   assign num_d      = swap ? pend_num : num;

   assign bad_hit = pix_valid & cur_valid & (in_hcnt == cur_x) & (in_vcnt == cur_y);
   assign past    = (in_vcnt > cur_y) | ((in_vcnt == cur_y) & (in_hcnt > cur_x));
   assign advance = pix_valid & cur_valid & (bad_hit | past);
   assign last    = (cur_idx == num - (PTR_W+1)'(1));

   // A read issued on the previous advance lands in rdata now, ahead of the nxt register.
   assign nxt_eff = rd_pend ? rdata : nxt;

   dpc_bp_ram #(
      .ADDR_W (PTR_W + 1),
      .DATA_W (ENTRY_W)
   ) u_ram (
      .clk   (axis_aclk),
      .wen   (wr_acc),
      .waddr ({~active_bank, cfg_waddr}),
      .wdata (wr_entry),
      .ren   (rd_en),
      .raddr ({active_bank, rd_idx}),
      .rdata (rdata)
   );

   always_comb begin
      state_d = state;
      rd_en   = 1'b0;
      rd_idx  = ptr;
      case (state)
         IDLE, DONE: ;
         PRELOAD: begin
            if (pl_cnt == PRELOAD_LAST) begin
               state_d = ARMED;
            end else begin
               rd_en  = 1'b1;
               rd_idx = PTR_W'(pl_cnt);
            end
         end
         ARMED: begin
            if (advance) begin
               if (last) begin
                  state_d = DONE;
               end else begin
                  rd_en = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      // A frame boundary restarts the walk on whichever bank is active after the swap.
      if (frame_end) begin
         state_d = (num_d != '0) ? PRELOAD : IDLE;
         rd_en   = 1'b0;
      end
   end

   always_ff @(posedge axis_aclk) begin
      if (reset) begin
         state       <= IDLE;
         pl_cnt      <= '0;
         active_bank <= 1'b0;
         num         <= '0;
         pend        <= 1'b0;
         pend_num    <= '0;
         hit_cnt     <= '0;
         hit_count   <= '0;
         underrun    <= 1'b0;
         order_err   <= 1'b0;
         cur_valid   <= 1'b0;
         rd_pend     <= 1'b0;
         ptr         <= PTR_W'(2);
         cur_idx     <= '0;
      end else begin
         state       <= state_d;
         active_bank <= bank_d;
         num         <= num_d;
         if (swap) begin
            pend <= 1'b0;
         end
         if (commit_acc) begin
            pend     <= 1'b1;
            pend_num <= (cfg_num > MAX_NUM) ? MAX_NUM : cfg_num;
         end
         if (pix_valid && state == PRELOAD) begin
            underrun <= 1'b1;
         end
         if (advance && !bad_hit) begin
            order_err <= 1'b1;
         end
         if (frame_end) begin
            hit_count <= hit_cnt + (PTR_W+1)'(bad_hit);
            hit_cnt   <= '0;
         end else if (bad_hit) begin
            hit_cnt <= hit_cnt + (PTR_W+1)'(1);
         end

         if (frame_end) begin
            pl_cnt    <= '0;
            cur_valid <= 1'b0;
            rd_pend   <= 1'b0;
            ptr       <= PTR_W'(2);
            cur_idx   <= '0;
         end else begin
            case (state)
               PRELOAD: begin
                  pl_cnt <= pl_cnt + 2'd1;
                  if (pl_cnt == PRELOAD_LAST) begin
                     cur_valid <= 1'b1;
                  end
               end
               ARMED: begin
                  rd_pend <= 1'b0;
                  if (advance) begin
                     if (last) begin
                        cur_valid <= 1'b0;
                     end else begin
                        ptr     <= ptr + PTR_W'(1);
                        cur_idx <= cur_idx + (PTR_W+1)'(1);
                        rd_pend <= 1'b1;
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

   // Coordinate datapath carries no reset; cur_valid qualifies it.
   always_ff @(posedge axis_aclk) begin
      nxt <= nxt_eff;
      if (state == PRELOAD && pl_cnt == 2'd1) begin
         cur <= rdata;
      end
      if (state == PRELOAD && pl_cnt == PRELOAD_LAST) begin
         nxt <= rdata;
      end
      if (state == ARMED && advance && !last) begin
         cur <= nxt_eff;
      end
   end

endmodule
